rotate_cmd_gen: RTL and testbench

Front-end stage that turns two raw push-button inputs into the step commands for the 8-bit rotator. Buttons are synchronised and debounced, then a direction state machine emits one-cycle step pulses at a programmable rate. `left_cmd` drives the rotator's `in1` (rotate left) and `right_cmd` drives its `in2` (rotate right). The two commands are never high in the same cycle.

---
 rtl/rotate_cmd_pkg.sv | 16 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/rotate_cmd_gen.sv | 97 +++++++++
 tb/tb_rotate_cmd_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rotate_cmd_pkg.sv
// Shared types and helpers for the rotator command front end.
// Direction codes double as the externally visible dir_state encoding.
package rotate_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } dir_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return $clog2((n < 2) ? 2 : n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer for one button.
// The debounced level only follows the synchronised level after it has disagreed for DEBOUNCE edges.
module btn_debounce
    import rotate_cmd_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int CW = cntWidth(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          syncMeta_q;
    logic          syncOut_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
        end else begin
            syncMeta_q <= btn_raw;
            syncOut_q  <= syncMeta_q;
        end
    end

    // Any agreement between the synchronised and debounced levels restarts the run.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (syncOut_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = syncOut_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign btn_deb = deb_q;

endmodule

// File: rtl/rotate_cmd_gen.sv
// Turns two raw buttons into mutually exclusive one-cycle rotate-left / rotate-right step pulses.
// Debounced levels drive a direction FSM that re-issues a step every STEP_DIV cycles while held.
module rotate_cmd_gen
    import rotate_cmd_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int STEP_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       left_cmd,
    output logic       right_cmd,
    output logic [1:0] dir_state
);

    localparam int SW = cntWidth(STEP_DIV);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_DIV - 1);

    logic          debLeft;
    logic          debRight;
    dir_t          state_q;
    logic [SW-1:0] stepCnt_q;
    logic          leftCmd_q;
    logic          rightCmd_q;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) uDebLeft (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_left),
        .btn_deb (debLeft)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) uDebRight (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_right),
        .btn_deb (debRight)
    );

    // Entry pulses immediately; a conflict or release always drops back to IDLE first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            stepCnt_q  <= '0;
            leftCmd_q  <= 1'b0;
            rightCmd_q <= 1'b0;
        end else begin
            leftCmd_q  <= 1'b0;
            rightCmd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    stepCnt_q <= '0;
                    if (debLeft && !debRight) begin
                        state_q   <= LEFT;
                        leftCmd_q <= 1'b1;
                    end else if (debRight && !debLeft) begin
                        state_q    <= RIGHT;
                        rightCmd_q <= 1'b1;
                    end
                end
                LEFT: begin
                    if (!debLeft || debRight) begin
                        state_q   <= IDLE;
                        stepCnt_q <= '0;
                    end else if (stepCnt_q == STEP_MAX) begin
                        leftCmd_q <= 1'b1;
                        stepCnt_q <= '0;
                    end else begin
                        stepCnt_q <= stepCnt_q + SW'(1);
                    end
                end
                RIGHT: begin
                    if (!debRight || debLeft) begin
                        state_q   <= IDLE;
                        stepCnt_q <= '0;
                    end else if (stepCnt_q == STEP_MAX) begin
                        rightCmd_q <= 1'b1;
                        stepCnt_q  <= '0;
                    end else begin
                        stepCnt_q <= stepCnt_q + SW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    stepCnt_q <= '0;
                end
            endcase
        end
    end

    assign left_cmd  = leftCmd_q;
    assign right_cmd = rightCmd_q;
    assign dir_state = state_q;

endmodule

// File: tb/tb_rotate_cmd_gen.sv
// Drives two builds (STEP_DIV 8 and 1) with identical directed and random button traffic
// and compares every cycle against a cycle-history reference model.
module tb_rotate_cmd_gen;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnLeft;
    logic       btnRight;
    logic       leftCmd  [2];
    logic       rightCmd [2];
    logic [1:0] dirState [2];

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    int stepDiv [2] = '{8, 1};

    bit s0 [2];
    bit s1 [2];
    bit d  [2];
    bit hist [2][$];
    int mDir [2];
    int mAge [2];

    always #5 clk = ~clk;

    rotate_cmd_gen #(.DEBOUNCE(DEB), .STEP_DIV(8)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .btn_left  (btnLeft),
        .btn_right (btnRight),
        .left_cmd  (leftCmd[0]),
        .right_cmd (rightCmd[0]),
        .dir_state (dirState[0])
    );

    rotate_cmd_gen #(.DEBOUNCE(DEB), .STEP_DIV(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .btn_left  (btnLeft),
        .btn_right (btnRight),
        .left_cmd  (leftCmd[1]),
        .right_cmd (rightCmd[1]),
        .dir_state (dirState[1])
    );

    // A debounced level flips once the last DEB samples it saw all disagreed with it.
    task automatic modelStep(input bit rawL, input bit rawR, input bit rst);
        bit nd [2];
        bit flip;
        bit dl;
        bit dr;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                s0[b] = 0;
                s1[b] = 0;
                d[b]  = 0;
                hist[b].delete();
            end
            for (int u = 0; u < 2; u++) begin
                mDir[u] = 0;
                mAge[u] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                hist[b].push_back(s1[b]);
                if (hist[b].size() > DEB) void'(hist[b].pop_front());
                flip = (hist[b].size() == DEB);
                foreach (hist[b][i]) if (hist[b][i] == d[b]) flip = 0;
                nd[b] = flip ? !d[b] : d[b];
            end
            dl = d[0];
            dr = d[1];
            for (int u = 0; u < 2; u++) begin
                case (mDir[u])
                    0: begin
                        if (dl && !dr) begin mDir[u] = 1; mAge[u] = 0; end
                        else if (dr && !dl) begin mDir[u] = 2; mAge[u] = 0; end
                    end
                    1: if (!dl || dr) mDir[u] = 0; else mAge[u]++;
                    default: if (!dr || dl) mDir[u] = 0; else mAge[u]++;
                endcase
            end
            s1[0] = s0[0];
            s1[1] = s0[1];
            s0[0] = rawL;
            s0[1] = rawR;
            d[0]  = nd[0];
            d[1]  = nd[1];
        end
    endtask

    task automatic checkOutput();
        logic       expL;
        logic       expR;
        logic [1:0] expD;
        for (int u = 0; u < 2; u++) begin
            expL = (mDir[u] == 1) && (mAge[u] % stepDiv[u] == 0);
            expR = (mDir[u] == 2) && (mAge[u] % stepDiv[u] == 0);
            expD = 2'(mDir[u]);
            total++;
            assert (leftCmd[u] === expL) else begin
                bad++;
                $error("[TB] FAIL left_cmd[%0d] cycle %0d got %b expected %b", u, cycle, leftCmd[u], expL);
            end
            total++;
            assert (rightCmd[u] === expR) else begin
                bad++;
                $error("[TB] FAIL right_cmd[%0d] cycle %0d got %b expected %b", u, cycle, rightCmd[u], expR);
            end
            total++;
            assert (dirState[u] === expD) else begin
                bad++;
                $error("[TB] FAIL dir_state[%0d] cycle %0d got %b expected %b", u, cycle, dirState[u], expD);
            end
            total++;
            assert ((leftCmd[u] & rightCmd[u]) === 1'b0) else begin
                bad++;
                $error("[TB] FAIL exclusive[%0d] cycle %0d got %b%b expected not both high", u, cycle, leftCmd[u], rightCmd[u]);
            end
        end
    endtask

    task automatic applyStimulus(input bit l, input bit r, input bit rst);
        btnLeft  = l;
        btnRight = r;
        reset    = rst;
        @(posedge clk);
        modelStep(l, r, rst);
        cycle++;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int mode;
        int len;
        int seen;
        btnLeft  = 0;
        btnRight = 0;
        reset    = 1;
        @(negedge clk);

        $display("[TB] reset with both buttons held");
        repeat (10) applyStimulus(1, 1, 1);
        repeat (3)  applyStimulus(1, 1, 0);

        $display("[TB] left hold");
        repeat (40) applyStimulus(1, 0, 0);
        repeat (12) applyStimulus(0, 0, 0);

        $display("[TB] bouncing right button");
        for (int i = 0; i < 12; i++) applyStimulus(0, ((i / 2) % 2) == 0, 0);
        repeat (30) applyStimulus(0, 1, 0);
        repeat (12) applyStimulus(0, 0, 0);

        $display("[TB] conflict");
        repeat (15) applyStimulus(1, 0, 0);
        repeat (15) applyStimulus(1, 1, 0);
        repeat (20) applyStimulus(0, 1, 0);
        repeat (12) applyStimulus(0, 0, 0);

        $display("[TB] reset mid-hold");
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            applyStimulus(1, 0, 0);
            if (mDir[0] == 1 && mAge[0] % stepDiv[0] == 0) seen++;
        end
        repeat (3)  applyStimulus(1, 0, 0);
        repeat (2)  applyStimulus(1, 0, 1);
        repeat (25) applyStimulus(1, 0, 0);
        repeat (12) applyStimulus(0, 0, 0);

        $display("[TB] random traffic");
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 4);
            len  = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                case (mode)
                    0: applyStimulus(0, 0, 0);
                    1: applyStimulus(1, 0, 0);
                    2: applyStimulus(0, 1, 0);
                    3: applyStimulus(1, 1, 0);
                    default: applyStimulus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 19) == 0));
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
